// File: rtl/layer_sequencer.sv
// Moore sequencer that steps the shared forward-net datapath through
// LOAD / COMPUTE / DRAIN / WB for each layer, then holds the result for a ready/valid handshake.
//
// state   | meaning
// IDLE    | waiting for start; done pulses here for one cycle after a handshake
// LOAD    | operand register load, accumulator clear
// COMPUTE | accumulate for MAC_CYCLES cycles
// DRAIN   | wait PIPE_DELAY cycles for the shifter/clip pipeline
// WB      | write activation register, advance layer
// OUT     | result valid, waiting for out_ready
module layer_sequencer #(
  parameter int N_LAYERS   = 3,
  parameter int MAC_CYCLES = 6,
  parameter int PIPE_DELAY = 3,
  localparam int LW = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          out_ready,
  output logic          busy,
  output logic          sel_feedback,
  output logic          in_reg_en,
  output logic          acc_clr,
  output logic          acc_en,
  output logic          act_reg_en,
  output logic [LW-1:0] layer_idx,
  output logic          out_valid,
  output logic          done
);

  localparam int CNT_MAX_A = (MAC_CYCLES > PIPE_DELAY) ? MAC_CYCLES : PIPE_DELAY;
  localparam int CNT_MAX   = (CNT_MAX_A > 2) ? CNT_MAX_A : 2;
  localparam int CW        = $clog2(CNT_MAX);

  localparam logic [CW-1:0] MAC_LAST   = CW'(MAC_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LAST = (PIPE_DELAY > 0) ? CW'(PIPE_DELAY - 1) : '0;
  localparam logic [LW-1:0] LAST_LAYER = LW'(N_LAYERS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    COMPUTE = 3'd2,
    DRAIN   = 3'd3,
    WB      = 3'd4,
    OUT     = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [LW-1:0]   layer_q, layer_d;
  logic            done_q, done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      layer_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      layer_q <= layer_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    layer_d = layer_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      layer_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = LOAD;
            layer_d = '0;
          end
        end
        LOAD: begin
          state_d = COMPUTE;
          cnt_d   = '0;
        end
        COMPUTE: begin
          if (cnt_q == MAC_LAST) begin
            cnt_d   = '0;
            state_d = (PIPE_DELAY == 0) ? WB : DRAIN;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        DRAIN: begin
          if (cnt_q == DRAIN_LAST) begin
            cnt_d   = '0;
            state_d = WB;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        WB: begin
          if (layer_q == LAST_LAYER) begin
            state_d = OUT;
          end else begin
            layer_d = layer_q + LW'(1);
            state_d = LOAD;
          end
        end
        OUT: begin
          // layer_idx returns to 0 so IDLE always presents the reset view
          if (out_ready) begin
            state_d = IDLE;
            layer_d = '0;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          layer_d = '0;
        end
      endcase
    end
  end

  assign busy         = (state_q != IDLE);
  assign sel_feedback = (state_q == LOAD) && (layer_q != '0);
  assign in_reg_en    = (state_q == LOAD);
  assign acc_clr      = (state_q == LOAD);
  assign acc_en       = (state_q == COMPUTE);
  assign act_reg_en   = (state_q == WB);
  assign out_valid    = (state_q == OUT);
  assign layer_idx    = layer_q;
  assign done         = done_q;

endmodule
